// File: rtl/alu_driver_if.sv
// alu_driver_if: command and response handshake bundle for alu_driver.
// The master side offers commands and consumes responses; the slave side
// (alu_driver) accepts commands and presents responses.
interface alu_driver_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_r;
  logic             rsp_z;
  logic [2:0]       rsp_op;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_r, rsp_z, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_r, rsp_z, rsp_op
  );
endinterface

// File: rtl/alu_driver.sv
// alu_driver: command-side initiator for the registered 32-bit ALU.
// Commands are buffered in a DEPTH-entry FIFO and issued one at a time;
// the FSM waits out the ALU's one-cycle registered latency, captures R and
// Zflag, and returns them in command order over a valid/ready response.
// Optional feature: define ALU_DRV_STATS_EN to add the stat_ops/stat_zero
// response counters (16-bit, wrapping).
module alu_driver #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_driver_if.slave      bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_z,
  output logic             busy
`ifdef ALU_DRV_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_zero
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       state;
  logic [2:0]       op_q;

  logic [2:0]       mem_op [DEPTH];
  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             push;
  logic             pop;
  logic             fifo_empty;

  // cmd_ready depends on the FIFO count alone, never on cmd_valid or rsp_ready.
  assign bus.cmd_ready = (count != (AW+1)'(DEPTH));
  assign fifo_empty    = (count == '0);
  assign busy          = (state != S_IDLE) || !fifo_empty;

  // Handshake decode: a pop happens whenever the FSM issues the FIFO head.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    push = 1'b0;
    pop  = 1'b0;
    push = bus.cmd_valid && bus.cmd_ready;
    if (!fifo_empty) begin
      pop = (state == S_IDLE) || ((state == S_HOLD) && bus.rsp_ready);
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count gates every read.
    if (push) begin
      mem_op[wr_ptr] <= bus.cmd_op;
      mem_a[wr_ptr]  <= bus.cmd_a;
      mem_b[wr_ptr]  <= bus.cmd_b;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue/execute/capture/hold sequencer driving the ALU and the response side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sel       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_r     <= '0;
      bus.rsp_z     <= 1'b0;
      bus.rsp_op    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            alu_a   <= mem_a[rd_ptr];
            alu_b   <= mem_b[rd_ptr];
            alu_sel <= mem_op[rd_ptr];
            op_q    <= mem_op[rd_ptr];
            state   <= S_EXEC;
          end
        end
        // The ALU registers its inputs at the edge that leaves EXEC.
        S_EXEC: state <= S_CAPT;
        S_CAPT: begin
          bus.rsp_r     <= alu_r;
          bus.rsp_z     <= alu_z;
          bus.rsp_op    <= op_q;
          bus.rsp_valid <= 1'b1;
          state         <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            if (pop) begin
              alu_a   <= mem_a[rd_ptr];
              alu_b   <= mem_b[rd_ptr];
              alu_sel <= mem_op[rd_ptr];
              op_q    <= mem_op[rd_ptr];
              state   <= S_EXEC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_DRV_STATS_EN
  // Response counters: every handshake, and handshakes carrying a zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_zero <= '0;
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      stat_ops <= stat_ops + 1'b1;
      if (bus.rsp_z) stat_zero <= stat_zero + 1'b1;
    end
  end
`endif

endmodule

// File: doc/alu_driver.md
# alu_driver

Command-side initiator for the 32-bit ALU. It accepts operation commands (opcode, A, B) over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time on the ALU's A/B/Sel inputs, captures the registered result and zero flag, and returns them over a valid/ready response handshake. It sits between the control logic and the ALU so that callers never have to track the ALU's one-cycle registered latency.

## Interface
- WIDTH, 32: operand/result width; must match the ALU.
- DEPTH, 4: command FIFO entries; power of two, ≥ 2.

- CLK  in  1  rising-edge clock, shared with the ALU
- RST_N  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= not full)
- cmd_op  in  3  ALU opcode, passed unchanged to Sel
- cmd_a, cmd_b  in  WIDTH  operands
- alu_a, alu_b  out  WIDTH  to ALU A, B (registered)
- alu_sel  out  3  to ALU Sel (registered)
- alu_r  in  WIDTH  from ALU R
- alu_z  in  1  from ALU Zflag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_r  out  WIDTH  captured result
- rsp_z  out  1  captured zero flag
- rsp_op  out  3  opcode that produced the result
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- Reset values: all of the following are 0 — FIFO pointers and count, alu_a, alu_b, alu_sel, rsp_valid, rsp_r, rsp_z, rsp_op, busy. State is IDLE. cmd_ready is 1.
- Push: occurs when cmd_valid && cmd_ready at an edge.
- FIFO pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves the count unchanged.
- A push while full is impossible because cmd_ready is low.
- FSM states: IDLE, EXEC, CAPT, HOLD.
  - IDLE: if the FIFO is non-empty, load alu_a/alu_b/alu_sel and an internal op register from the FIFO head, pop, and go to EXEC.
  - EXEC: the ALU samples its inputs at this edge. Go to CAPT.
  - CAPT: sample alu_r/alu_z into rsp_r/rsp_z, copy the op register to rsp_op, set rsp_valid, and go to HOLD.
  - HOLD: if rsp_ready, clear rsp_valid. Then, if the FIFO is non-empty, issue the head (same as IDLE) and go to EXEC; otherwise go to IDLE. If rsp_ready is low, stay in HOLD.
- While rsp_valid && !rsp_ready, rsp_r, rsp_z and rsp_op are held stable.
- alu_a/alu_b/alu_sel hold their last issued values between issues.
- Opcodes 110 and 111 are forwarded as-is; the ALU treats them as add.
- Results return strictly in command order.
- Reset mid-operation discards the FIFO contents and any in-flight command. The ALU's unreset R register is ignored because the FSM restarts in IDLE.

## Timing
- Command accepted at edge N:
  - issued at edge N+1, when the FIFO is empty and the FSM is in IDLE;
  - ALU registers R at N+2;
  - rsp_valid rises at N+3.
- Latency is therefore 3 cycles from accept to rsp_valid.
- Sustained throughput with rsp_ready tied high: one result every 3 cycles. rsp_valid pulses for 1 cycle out of every 3.
- cmd_ready is combinational from the FIFO count only; it has no path from cmd_valid or rsp_ready.
- Capacity under backpressure: DEPTH + 1 commands. One command is held in the response/ALU path and DEPTH are buffered.

## Configuration
- ALU_DRV_STATS_EN defined:
  - adds outputs stat_ops (16) and stat_zero (16), both reset to 0;
  - stat_ops increments on every response handshake;
  - stat_zero increments on every response handshake with rsp_z = 1;
  - both counters wrap modulo 2^16.
- ALU_DRV_STATS_EN undefined: both ports and their counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset: hold RST_N low mid-traffic → rsp_valid=0, alu_sel=0, busy=0 and cmd_ready=1, all immediately without waiting for a clock edge.
- Single add: op 000, A=5, B=7, rsp_ready=1 → rsp_valid 3 cycles after accept with rsp_r=12, rsp_z=0, rsp_op=000.
- Zero flag: op 100, A=9, B=9 → rsp_r=0, rsp_z=1. With ALU_DRV_STATS_EN: stat_ops=1, stat_zero=1.
- Ordering: issue these four commands back-to-back:
  - op 001, 0xF0F0 & 0x0FF0 → 0x00F0;
  - op 010, same operands → 0xFFF0;
  - op 101, A=3, B=4 → 1;
  - op 011, A=6, B=7 → 42.
  Required: results arrive in that order, spaced 3 cycles apart.
- Backpressure: rsp_ready=0, offer DEPTH+2 commands → cmd_ready drops after DEPTH+1 accepts, and rsp_* stay stable. Then raise rsp_ready → all DEPTH+1 results drain in order and cmd_ready returns to 1.
- Reset mid-op: assert RST_N in EXEC, then release → no rsp_valid appears, busy=0, and the next command completes normally.
